// File: rtl/store_unit.sv
//------------------------------------------------------------------------------
// Module  : store_unit
// Purpose : RISC-V SB/SH/SW store engine with read-modify-write for sub-word stores.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 256,
  localparam int IW        = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  output logic                  resp_error,
  output logic [IW-1:0]         mem_addr,
  output logic                  mem_rd_en,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_wr_en,
  output logic [31:0]           mem_wdata,
  output logic [15:0]           store_count
);

  localparam logic [2:0] C_F3_SB = 3'b000;
  localparam logic [2:0] C_F3_SH = 3'b001;
  localparam logic [2:0] C_F3_SW = 3'b010;
  localparam logic [ADDR_WIDTH-2:0] C_MEM_WORDS = (ADDR_WIDTH-1)'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IW-1:0]     r_index;
  logic [1:0]        r_lane;
  logic [31:0]       r_data;
  logic              r_half;
  logic              r_error;
  logic [15:0]       r_count;

  logic              w_handshake;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_error;
  logic [ADDR_WIDTH-2:0] w_word_num;
  logic [31:0]       w_merged;

  assign w_handshake    = req_valid && (state == S_IDLE);
  assign w_illegal      = (req_funct3 != C_F3_SB) && (req_funct3 != C_F3_SH) &&
                          (req_funct3 != C_F3_SW);
  assign w_misaligned   = ((req_funct3 == C_F3_SH) && req_addr[0]) ||
                          ((req_funct3 == C_F3_SW) && (req_addr[1:0] != 2'b00));
  assign w_word_num     = {1'b0, req_addr[ADDR_WIDTH-1:2]};
  assign w_out_of_range = (w_word_num >= C_MEM_WORDS);
  assign w_error        = w_illegal || w_misaligned || w_out_of_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_index <= '0;
      r_lane  <= 2'b00;
      r_data  <= 32'h0;
      r_half  <= 1'b0;
      r_error <= 1'b0;
    end else if (w_handshake) begin
      r_index <= req_addr[IW+1:2];
      r_lane  <= req_addr[1:0];
      r_data  <= req_data;
      r_half  <= (req_funct3 == C_F3_SH);
      r_error <= w_error;
    end
  end

  // Counted on the edge that leaves RESP, so the response cycle still shows the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 16'h0;
    end else if ((state == S_RESP) && !r_error) begin
      r_count <= r_count + 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_error) begin
            state_next = S_RESP;
          end else if (req_funct3 == C_F3_SW) begin
            state_next = S_WRITE;
          end else begin
            state_next = S_READ;
          end
        end
      end
      S_READ:  state_next = S_MERGE;
      S_MERGE: state_next = S_RESP;
      S_WRITE: state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Little-endian lane replacement over the word just read back.
  always_comb begin
    w_merged = mem_rdata;
    if (r_half) begin
      if (r_lane[1]) begin
        w_merged[31:16] = r_data[15:0];
      end else begin
        w_merged[15:0]  = r_data[15:0];
      end
    end else begin
      w_merged[{r_lane, 3'b000} +: 8] = r_data[7:0];
    end
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
    resp_error = (state == S_RESP) && r_error;
    mem_rd_en  = (state == S_READ);
    mem_wr_en  = (state == S_MERGE) || (state == S_WRITE);
    mem_addr   = r_index;
    mem_wdata  = 32'h0;
    if (state == S_MERGE) begin
      mem_wdata = w_merged;
    end else if (state == S_WRITE) begin
      mem_wdata = r_data;
    end
  end

  assign store_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_store_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_store_unit
// Purpose : Scoreboard bench for store_unit with a behavioural word memory.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_store_unit;

  localparam int AW = 32;
  localparam int MW = 256;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic [2:0]    req_funct3;
  logic          resp_valid;
  logic          resp_error;
  logic [IW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [31:0]   mem_rdata;
  logic          mem_wr_en;
  logic [31:0]   mem_wdata;
  logic [15:0]   store_count;

  store_unit #(.ADDR_WIDTH(AW), .MEM_WORDS(MW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_funct3  (req_funct3),
    .resp_valid  (resp_valid),
    .resp_error  (resp_error),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rdata   (mem_rdata),
    .mem_wr_en   (mem_wr_en),
    .mem_wdata   (mem_wdata),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:MW-1];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic err;
    int   lat;
    logic rd;
    logic wr;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   hs_cyc   = 0;
  logic saw_rd   = 1'b0;
  logic saw_wr   = 1'b0;
  logic overlap  = 1'b0;

  task automatic check_val(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Handshake capture uses pre-edge values of req_valid/req_ready.
  always @(posedge clk) begin
    if (req_valid && req_ready) hs_cyc <= cyc;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (mem_rd_en && mem_wr_en) overlap = 1'b1;
    if (req_ready) begin
      saw_rd = 1'b0;
      saw_wr = 1'b0;
    end
    if (mem_rd_en) saw_rd = 1'b1;
    if (mem_wr_en) saw_wr = 1'b1;
    if (resp_valid) begin
      if (q.size() == 0) begin
        check_val("unexpected_resp", 1, 0);
      end else begin
        e = q.pop_front();
        check_val("resp_error", resp_error, e.err);
        check_val("resp_latency", cyc - hs_cyc, e.lat);
        check_val("rd_strobe_seen", saw_rd, e.rd);
        check_val("wr_strobe_seen", saw_wr, e.wr);
        check_val("strobe_overlap", overlap, 0);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic err, input int lat, input logic rd, input logic wr,
                       input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_val("ready_timeout", 0, 1);
    if (push) q.push_back('{err: err, lat: lat, rd: rd, wr: wr});
    req_valid  = 1'b1;
    req_addr   = a;
    req_data   = d;
    req_funct3 = f;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic wait_done();
    repeat (6) @(negedge clk);
    check_val("pending_responses", q.size(), 0);
    q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"},   req_ready,   1);
    check_val({tag, "_resp_valid"},  resp_valid,  0);
    check_val({tag, "_resp_error"},  resp_error,  0);
    check_val({tag, "_mem_rd_en"},   mem_rd_en,   0);
    check_val({tag, "_mem_wr_en"},   mem_wr_en,   0);
    check_val({tag, "_mem_addr"},    mem_addr,    0);
    check_val({tag, "_mem_wdata"},   mem_wdata,   0);
    check_val({tag, "_store_count"}, store_count, 0);
  endtask

  initial begin
    int n;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_funct3 = 3'b000;
    mem_rdata  <= 32'h0;
    for (int i = 0; i < MW; i++) mem[i] <= 32'h0;
    mem[0] <= 32'hFFFF_FFFF;
    mem[1] <= 32'h1122_3344;
    mem[2] <= 32'h5566_7788;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // Sub-word and full-word stores
    issue(32'h05, 32'hAABB_CCDD, 3'b000, 1'b0, 3, 1'b1, 1'b1, 1'b1);
    wait_done();
    check_val("sb_mem1", mem[1], 32'h1122_DD44);
    check_val("sb_count", store_count, 1);

    issue(32'h0A, 32'h0000_BEEF, 3'b001, 1'b0, 3, 1'b1, 1'b1, 1'b1);
    wait_done();
    check_val("sh_mem2", mem[2], 32'hBEEF_7788);
    check_val("sh_count", store_count, 2);

    issue(32'h0C, 32'hDEAD_BEEF, 3'b010, 1'b0, 2, 1'b0, 1'b1, 1'b1);
    wait_done();
    check_val("sw_mem3", mem[3], 32'hDEAD_BEEF);
    check_val("sw_count", store_count, 3);

    issue(32'h07, 32'h0000_0099, 3'b000, 1'b0, 3, 1'b1, 1'b1, 1'b1);
    wait_done();
    check_val("sb_lane3_mem1", mem[1], 32'h9922_DD44);

    // Rejected requests
    issue(32'h03, 32'h0000_1234, 3'b001, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(32'h0E, 32'h1234_5678, 3'b010, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(32'h10, 32'h1234_5678, 3'b011, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(MW * 4, 32'h1234_5678, 3'b010, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    wait_done();
    check_val("err_mem0", mem[0], 32'hFFFF_FFFF);
    check_val("err_mem3", mem[3], 32'hDEAD_BEEF);
    check_val("err_mem4", mem[4], 32'h0);
    check_val("err_count", store_count, 4);

    // Reset during MERGE of SB to word 0
    issue(32'h00, 32'h0000_0055, 3'b000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!mem_wr_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("merge_reached", mem_wr_en, 1);
    reset = 1'b0;
    #1;
    check_val("async_wr_drop", mem_wr_en, 0);
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("midreset_mem0", mem[0], 32'hFFFF_FFFF);
    check_val("midreset_no_resp", q.size(), 0);

    issue(32'h10, 32'hCAFE_F00D, 3'b010, 1'b0, 2, 1'b0, 1'b1, 1'b1);
    wait_done();
    check_val("post_reset_mem4", mem[4], 32'hCAFE_F00D);
    check_val("post_reset_count", store_count, 1);

    // Counter wrap
    @(negedge clk);
    force dut.r_count = 16'hFFFF;
    #1;
    release dut.r_count;
    check_val("count_preload", store_count, 16'hFFFF);
    issue(32'h14, 32'h0BAD_CAFE, 3'b010, 1'b0, 2, 1'b0, 1'b1, 1'b1);
    wait_done();
    check_val("wrap_mem5", mem[5], 32'h0BAD_CAFE);
    check_val("count_wrap", store_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
